// File: rtl/utc_to_unix64.sv
// utc_to_unix64: converts a UTC calendar date/time to 64-bit signed Unix seconds.
// The conversion is iterative: it peels off 400/100/4/1-year blocks, then whole
// months, then day/hour/minute/second, and finally subtracts the 0001..1970 offset.
//
// Ports:
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous active-high reset
//   start      in   1   conversion request, accepted only while busy=0
//   year       in  14   calendar year 1..16383
//   month      in   4   1..12
//   day        in   5   1..days-in-month (leap-aware)
//   hour       in   5   0..23
//   minute     in   6   0..59
//   second     in   6   0..59
//   unix_time  out 64   two's-complement seconds since 1970-01-01 00:00:00 UTC
//   done       out  1   one-cycle completion pulse
//   err        out  1   valid with done, 1 = inputs rejected
//   busy       out  1   high from the accepting edge through the done cycle
module utc_to_unix64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    input  logic [4:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    output logic [63:0] unix_time,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam int unsigned ACC_W = 64;
    localparam int unsigned YEAR_W = 14;

    localparam logic [ACC_W-1:0] SEC_PER_DAY   = 64'd86400;
    localparam logic [ACC_W-1:0] SEC_PER_HOUR  = 64'd3600;
    localparam logic [ACC_W-1:0] SEC_PER_MIN   = 64'd60;
    localparam logic [ACC_W-1:0] SEC_Y400      = 64'd12622780800;
    localparam logic [ACC_W-1:0] SEC_Y100      = 64'd3155673600;
    localparam logic [ACC_W-1:0] SEC_Y4        = 64'd126230400;
    localparam logic [ACC_W-1:0] SEC_Y1        = 64'd31536000;
    localparam logic [ACC_W-1:0] EPOCH_OFFSET  = 64'd62135596800;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        Y400,
        Y100,
        Y4,
        Y1,
        MONTH,
        HMS,
        DONE
    } state_t;

    state_t state, state_n;

    logic [YEAR_W-1:0] year_q, year_n;
    logic [3:0]        month_q, month_n;
    logic [4:0]        day_q, day_n;
    logic [4:0]        hour_q, hour_n;
    logic [5:0]        minute_q, minute_n;
    logic [5:0]        second_q, second_n;
    logic              leap_q, leap_n;
    logic [YEAR_W-1:0] y_q, y_n;
    logic [3:0]        m_q, m_n;
    logic [ACC_W-1:0]  acc_q, acc_n;
    logic [ACC_W-1:0]  unix_n;
    logic              done_n, err_n, busy_n;

    logic              leap_c;
    logic              valid_c;
    logic [ACC_W-1:0]  hms_c;

    // Days in month m; 0 for an out-of-range month so any day check fails.
    function automatic logic [4:0] dim(input logic [3:0] m, input logic leap);
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: dim = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    dim = 5'd30;
            4'd2:                                       dim = leap ? 5'd29 : 5'd28;
            default:                                    dim = 5'd0;
        endcase
    endfunction

    // Gregorian leap rule on the latched year.
    always_comb begin
        leap_c = ((year_q[1:0] == 2'd0) && ((year_q % 14'd100) != 14'd0))
               || ((year_q % 14'd400) == 14'd0);
    end

    // Range check of every latched field.
    always_comb begin
        valid_c = (year_q != 14'd0)
               && (month_q >= 4'd1) && (month_q <= 4'd12)
               && (day_q >= 5'd1) && (day_q <= dim(month_q, leap_c))
               && (hour_q <= 5'd23)
               && (minute_q <= 6'd59)
               && (second_q <= 6'd59);
    end

    // Seconds contributed by the day-of-month and time-of-day fields.
    always_comb begin
        hms_c = 64'(day_q - 5'd1) * SEC_PER_DAY
              + 64'(hour_q) * SEC_PER_HOUR
              + 64'(minute_q) * SEC_PER_MIN
              + 64'(second_q);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            year_q    <= '0;
            month_q   <= '0;
            day_q     <= '0;
            hour_q    <= '0;
            minute_q  <= '0;
            second_q  <= '0;
            leap_q    <= 1'b0;
            y_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            unix_time <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            year_q    <= year_n;
            month_q   <= month_n;
            day_q     <= day_n;
            hour_q    <= hour_n;
            minute_q  <= minute_n;
            second_q  <= second_n;
            leap_q    <= leap_n;
            y_q       <= y_n;
            m_q       <= m_n;
            acc_q     <= acc_n;
            unix_time <= unix_n;
            done      <= done_n;
            err       <= err_n;
            busy      <= busy_n;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_n  = state;
        year_n   = year_q;
        month_n  = month_q;
        day_n    = day_q;
        hour_n   = hour_q;
        minute_n = minute_q;
        second_n = second_q;
        leap_n   = leap_q;
        y_n      = y_q;
        m_n      = m_q;
        acc_n    = acc_q;
        unix_n   = unix_time;
        err_n    = err;

        case (state)
            IDLE: begin
                if (start) begin
                    year_n   = year;
                    month_n  = month;
                    day_n    = day;
                    hour_n   = hour;
                    minute_n = minute;
                    second_n = second;
                    state_n  = CHECK;
                end
            end
            CHECK: begin
                leap_n = leap_c;
                if (!valid_c) begin
                    // unix_time is left untouched on rejection.
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    y_n     = year_q - 14'd1;
                    acc_n   = '0;
                    state_n = Y400;
                end
            end
            Y400: begin
                if (y_q >= 14'd400) begin
                    acc_n = acc_q + SEC_Y400;
                    y_n   = y_q - 14'd400;
                end else begin
                    state_n = Y100;
                end
            end
            Y100: begin
                if (y_q >= 14'd100) begin
                    acc_n = acc_q + SEC_Y100;
                    y_n   = y_q - 14'd100;
                end else begin
                    state_n = Y4;
                end
            end
            Y4: begin
                if (y_q >= 14'd4) begin
                    acc_n = acc_q + SEC_Y4;
                    y_n   = y_q - 14'd4;
                end else begin
                    state_n = Y1;
                end
            end
            Y1: begin
                if (y_q != 14'd0) begin
                    acc_n = acc_q + SEC_Y1;
                    y_n   = y_q - 14'd1;
                end else begin
                    m_n     = 4'd1;
                    state_n = MONTH;
                end
            end
            MONTH: begin
                // One month per cycle; the exit cycle adds nothing.
                if (m_q < month_q) begin
                    acc_n = acc_q + 64'(dim(m_q, leap_q)) * SEC_PER_DAY;
                    m_n   = m_q + 4'd1;
                end else begin
                    state_n = HMS;
                end
            end
            HMS: begin
                // Result is registered on entry to DONE so it is valid with done.
                acc_n   = acc_q + hms_c;
                unix_n  = acc_q + hms_c - EPOCH_OFFSET;
                err_n   = 1'b0;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        done_n = (state_n == DONE);
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_utc_to_unix64.sv
// tb_utc_to_unix64: directed and randomized bench for utc_to_unix64.
// Expected values come from a closed-form day-count model and a closed-form
// inverse (Unix seconds back to a civil date) used for round-trip checks.
module tb_utc_to_unix64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [63:0] unix_time;
    logic        done;
    logic        err;
    logic        busy;

    int vectors;
    int miscompares;

    utc_to_unix64 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .unix_time (unix_time),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit is_leap(input longint y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int days_in_month(input longint y, input int m);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && is_leap(y)) return 29;
        return t[m-1];
    endfunction

    function automatic longint ref_unix(input longint y, input int mo, input int d,
                                        input int h, input int mi, input int s);
        longint days;
        longint p;
        p = y - 1;
        days = p * 365 + p / 4 - p / 100 + p / 400;
        for (int m = 1; m < mo; m++) days += days_in_month(y, m);
        days += d - 1;
        return days * 86400 + h * 3600 + mi * 60 + s - 64'sd62135596800;
    endfunction

    // Civil date from days since 1970-01-01 (proleptic Gregorian).
    function automatic logic [63:0] ref_from_unix(input longint t);
        longint days, rem, z, era, doe, yoe, yy, doy, mp, dd, mm;
        days = t / 86400;
        rem  = t % 86400;
        if (rem < 0) begin
            rem  += 86400;
            days -= 1;
        end
        z   = days + 719468;
        era = ((z >= 0) ? z : z - 146096) / 146097;
        doe = z - era * 146097;
        yoe = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
        yy  = yoe + era * 400;
        doy = doe - (365 * yoe + yoe / 4 - yoe / 100);
        mp  = (5 * doy + 2) / 153;
        dd  = doy - (153 * mp + 2) / 5 + 1;
        mm  = (mp < 10) ? mp + 3 : mp - 9;
        if (mm <= 2) yy += 1;
        return {24'd0, 14'(yy), 4'(mm), 5'(dd), 5'(rem / 3600), 6'((rem % 3600) / 60), 6'(rem % 60)};
    endfunction

    function automatic int ref_latency(input int y, input int mo);
        int r, n400, n100, n4, n1;
        r    = y - 1;
        n400 = r / 400; r = r % 400;
        n100 = r / 100; r = r % 100;
        n4   = r / 4;   n1 = r % 4;
        return 8 + n400 + n100 + n4 + n1 + (mo - 1);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int y, input int mo, input int d, input int h, input int mi, input int s);
        year   = 14'(y);
        month  = 4'(mo);
        day    = 5'(d);
        hour   = 5'(h);
        minute = 6'(mi);
        second = 6'(s);
    endtask

    // Counts cycles after the accepting edge; cycle 1 is the one right after it.
    task automatic wait_done(input int first_cyc, input int budget, output int lat);
        lat = 0;
        for (int c = first_cyc; c <= budget; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Called #1 after a rising edge with busy low; returns #1 after the done edge.
    task automatic convert(input int y, input int mo, input int d, input int h, input int mi,
                           input int s, output logic [63:0] ut, output logic e, output int lat);
        drive(y, mo, d, h, mi, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, 200, lat);
        ut = unix_time;
        e  = err;
        if (lat == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL timeout waiting for done y=%0d m=%0d", y, mo);
        end
    endtask

    // Checks done cycle has busy, then done drops and busy drops next cycle.
    task automatic check_pulse_end(input string tag);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ut, prev;
        logic        e;
        int          lat, seen;
        int          ry, rm, rd, rh, rmi, rs;
        longint      exp_t;

        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        drive(1970, 1, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_unix", unix_time, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Epoch itself, with its exact latency.
        convert(1970, 1, 1, 0, 0, 0, ut, e, lat);
        check("epoch_val", ut, 64'd0);
        check("epoch_err", 64'(e), 64'd0);
        check("epoch_lat", 64'(lat), 64'd33);
        check_pulse_end("epoch");

        convert(2000, 2, 29, 12, 34, 56, ut, e, lat);
        check("y2000_leap", ut, 64'd951827696);
        check("y2000_lat", 64'(lat), 64'(ref_latency(2000, 2)));
        check_pulse_end("y2000");

        convert(2038, 1, 19, 3, 14, 8, ut, e, lat);
        check("y2038", ut, 64'd2147483648);
        check_pulse_end("y2038");

        convert(1969, 12, 31, 23, 59, 59, ut, e, lat);
        check("pre_epoch", ut, 64'hFFFF_FFFF_FFFF_FFFF);
        check_pulse_end("pre_epoch");

        convert(1, 1, 1, 0, 0, 0, ut, e, lat);
        check("year1", ut, 64'(-64'sd62135596800));
        check("year1_lat", 64'(lat), 64'd8);
        prev = ut;
        check_pulse_end("year1");

        // Rejected inputs: 2-cycle latency, err set, previous result held.
        begin
            int bad[7][6] = '{
                '{2023, 2, 29, 0, 0, 0},
                '{1900, 2, 29, 0, 0, 0},
                '{2023, 13, 1, 0, 0, 0},
                '{2023, 1, 1, 24, 0, 0},
                '{0, 1, 1, 0, 0, 0},
                '{2023, 4, 31, 0, 0, 0},
                '{2023, 5, 0, 0, 60, 0}
            };
            for (int i = 0; i < 7; i++) begin
                convert(bad[i][0], bad[i][1], bad[i][2], bad[i][3], bad[i][4], bad[i][5], ut, e, lat);
                check($sformatf("bad%0d_err", i), 64'(e), 64'd1);
                check($sformatf("bad%0d_lat", i), 64'(lat), 64'd2);
                check($sformatf("bad%0d_hold", i), ut, prev);
                check_pulse_end($sformatf("bad%0d", i));
                check($sformatf("bad%0d_err_hold", i), 64'(err), 64'd1);
            end
        end

        convert(2400, 2, 29, 0, 0, 0, ut, e, lat);
        check("y2400_err", 64'(e), 64'd0);
        check("y2400_val", ut, 64'(ref_unix(2400, 2, 29, 0, 0, 0)));
        check_pulse_end("y2400");

        // Start while busy with different inputs must be ignored.
        drive(2000, 2, 29, 12, 34, 56);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive(1985, 7, 4, 1, 2, 3);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, 200, lat);
        check("busy_ign_seen", 64'(lat != 0), 64'd1);
        check("busy_ign_val", unix_time, 64'd951827696);
        // Start raised during the done cycle is not accepted at that edge.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("busy_ign_no_extra_done", 64'(seen), 64'd0);

        // Reset in the middle of a conversion aborts it.
        drive(9999, 12, 31, 23, 59, 59);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_unix", unix_time, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        convert(2023, 6, 15, 8, 30, 0, ut, e, lat);
        check("after_rst_val", ut, 64'(ref_unix(2023, 6, 15, 8, 30, 0)));
        check_pulse_end("after_rst");

        // Randomized valid dates: model value, latency and round trip.
        for (int i = 0; i < 40; i++) begin
            ry  = int'($urandom_range(9999, 1));
            rm  = int'($urandom_range(12, 1));
            rd  = int'($urandom_range(days_in_month(ry, rm), 1));
            rh  = int'($urandom_range(23, 0));
            rmi = int'($urandom_range(59, 0));
            rs  = int'($urandom_range(59, 0));
            exp_t = ref_unix(ry, rm, rd, rh, rmi, rs);
            convert(ry, rm, rd, rh, rmi, rs, ut, e, lat);
            check($sformatf("rnd%0d_val", i), ut, 64'(exp_t));
            check($sformatf("rnd%0d_err", i), 64'(e), 64'd0);
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(ref_latency(ry, rm)));
            check($sformatf("rnd%0d_trip", i), ref_from_unix(longint'(ut)),
                  {24'd0, 14'(ry), 4'(rm), 5'(rd), 5'(rh), 6'(rmi), 6'(rs)});
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/utc_to_unix64.md
UTC_TO_UNIX64 -- requirements
Module: utc_to_unix64

Interface
REQ-001 SHALL have no parameters; all constants fixed: 86400 s/day, epoch offset 62135596800 s (0001-01-01 to 1970-01-01).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  conversion request; accepted only when busy=0.
REQ-005 year  input  14  calendar year, valid 1..16383.
REQ-006 month  input  4  valid 1..12.
REQ-007 day  input  5  valid 1..days-in-month (leap-aware).
REQ-008 hour  input  5  valid 0..23.
REQ-009 minute  input  6  valid 0..59.
REQ-010 second  input  6  valid 0..59.
REQ-011 unix_time  output  64  two's-complement seconds since 1970-01-01 00:00:00 UTC, registered.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  registered; valid with done, 1 = inputs rejected.
REQ-014 busy  output  1  high from accepting edge until the done cycle inclusive.

Function
REQ-015 SHALL latch all six date/time inputs on the edge where start=1 and busy=0; later input changes have no effect on that conversion.
REQ-016 SHALL ignore start while busy=1; no queueing.
REQ-017 FSM states: IDLE, CHECK, Y400, Y100, Y4, Y1, MONTH, HMS, DONE; DONE returns to IDLE on the next edge.
REQ-018 CHECK: leap = (year%4==0 and year%100!=0) or year%400==0; any range violation of REQ-005..REQ-010 -> DONE with err=1, else Y400 with y=year-1, acc=0, err=0.
REQ-019 Y400: per cycle while y>=400, acc+=12622780800, y-=400; exit cycle when y<400.
REQ-020 Y100: per cycle while y>=100, acc+=3155673600, y-=100; exit when y<100.
REQ-021 Y4: per cycle while y>=4, acc+=126230400, y-=4; exit when y<4.
REQ-022 Y1: per cycle while y>=1, acc+=31536000, y-=1; exit when y==0.
REQ-023 MONTH: per cycle for m=1..month-1, acc+=dim(m)*86400, dim(2)=29 if leap else 28; exit cycle after last month (one exit cycle when month=1).
REQ-024 HMS: single cycle, acc+=(day-1)*86400+hour*3600+minute*60+second.
REQ-025 DONE: unix_time<=acc-62135596800 (mod 2^64), done=1; years before 1970 yield negative values.
REQ-026 Latency from accepting edge to done cycle SHALL be L = 8+n400+n100+n4+n1+(month-1) cycles (n = iteration counts); invalid input L=2; worst case ≤ 91.
REQ-027 acc SHALL be 64 bits; no intermediate overflow for any valid input.
REQ-028 On err, unix_time SHALL hold its previous value.
REQ-029 unix_time and err SHALL hold until the next done; done never high for two consecutive cycles.
REQ-030 start in the done cycle SHALL be ignored (busy=1); start in the following IDLE cycle accepted.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, unix_time=0, done=0, err=0, busy=0, acc=0, y=0.
REQ-032 rst asserted mid-conversion SHALL abort it with no done pulse; first start after rst release begins a fresh conversion.

Verification
REQ-033 1970-01-01 00:00:00 -> unix_time=0, err=0, done exactly 33 cycles after accept (n400=4,n100=3,n4=17,n1=1).
REQ-034 2000-02-29 12:34:56 -> 951827696; 2038-01-19 03:14:08 -> 2147483648.
REQ-035 1969-12-31 23:59:59 -> 0xFFFFFFFFFFFFFFFF; 0001-01-01 00:00:00 -> -62135596800.
REQ-036 2023-02-29, 1900-02-29, month=13, hour=24 each -> done after 2 cycles, err=1, unix_time unchanged; 2400-02-29 -> err=0.
REQ-037 start pulsed while busy with different inputs -> ignored, first result unchanged; rst mid-conversion -> outputs 0, no done.
REQ-038 Randomized valid dates 1..9999 -> unix_time matches reference model and unix64_to_UTC round-trip equality.
